// File: rtl/gbt_fifo_fill_fsm.sv
// Write-side controller for the GBT transmit FIFO: collects one frame from the source,
// raises READY for the reader, waits for the drain, then holds READY low for a gap.
module gbt_fifo_fill_fsm #(
    parameter  int DATA_WIDTH = 16,
    parameter  int MAX_WORDS  = 512,
    parameter  int MT_GUARD   = 4,
    parameter  int GAP_CYCLES = 3,
    localparam int CW         = $clog2(MAX_WORDS + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_din,
    input  logic                  i_dv,
    input  logic                  i_sof,
    input  logic                  i_eof,
    input  logic                  i_full,
    input  logic                  i_mt,
    output logic                  o_wr_en,
    output logic [DATA_WIDTH-1:0] o_dout,
    output logic                  o_ready,
    output logic                  o_busy,
    output logic                  o_ovfl,
    output logic [CW-1:0]         o_wcount
);

    localparam int TMAX = (MT_GUARD > GAP_CYCLES) ? MT_GUARD : GAP_CYCLES;
    localparam int TW   = (TMAX < 1) ? 1 : $clog2(TMAX + 1);
    localparam logic ONE_WORD_FRAME = (MAX_WORDS == 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_READY = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_wr_en;
    logic                  w_wr_en;
    logic [DATA_WIDTH-1:0] r_dout;
    logic [DATA_WIDTH-1:0] w_dout;
    logic                  r_ready;
    logic                  r_busy;
    logic                  r_ovfl;
    logic                  w_ovfl;
    logic [CW-1:0]         r_wcount;
    logic [CW-1:0]         w_wcount;
    logic [CW-1:0]         w_wcount_inc;
    logic [TW-1:0]         r_timer;
    logic [TW-1:0]         w_timer;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state, datapath and timer decode; timer holds the Ready guard, then the Gap length.
    always_comb begin
        w_next_state = r_state;
        w_wr_en      = 1'b0;
        w_dout       = r_dout;
        w_ovfl       = r_ovfl;
        w_wcount     = r_wcount;
        w_timer      = r_timer;
        w_wcount_inc = r_wcount + {{(CW-1){1'b0}}, 1'b1};
        case (r_state)
            ST_IDLE: begin
                if (i_dv && i_sof) begin
                    if (i_full) begin
                        w_ovfl = 1'b1;
                    end else begin
                        w_wr_en  = 1'b1;
                        w_dout   = i_din;
                        w_wcount = {{(CW-1){1'b0}}, 1'b1};
                        w_ovfl   = 1'b0;
                        if (i_eof || ONE_WORD_FRAME) begin
                            w_next_state = ST_READY;
                            w_timer      = TW'(MT_GUARD);
                        end else begin
                            w_next_state = ST_FILL;
                        end
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (i_dv) begin
                    if (i_full) begin
                        w_ovfl       = 1'b1;
                        w_next_state = ST_READY;
                        w_timer      = TW'(MT_GUARD);
                    end else begin
                        w_wr_en  = 1'b1;
                        w_dout   = i_din;
                        w_wcount = w_wcount_inc;
                        // Closing at the limit guarantees no word past MAX_WORDS is ever written.
                        if (i_eof || (w_wcount_inc == CW'(MAX_WORDS))) begin
                            w_next_state = ST_READY;
                            w_timer      = TW'(MT_GUARD);
                        end else begin
                            w_next_state = ST_FILL;
                        end
                    end
                end else begin
                    w_next_state = ST_FILL;
                end
            end
            ST_READY: begin
                if (r_timer != {TW{1'b0}}) begin
                    w_timer = r_timer - {{(TW-1){1'b0}}, 1'b1};
                end else if (i_mt) begin
                    w_next_state = ST_GAP;
                    w_timer      = TW'(GAP_CYCLES - 1);
                end else begin
                    w_next_state = ST_READY;
                end
            end
            ST_GAP: begin
                if (r_timer == {TW{1'b0}}) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_timer = r_timer - {{(TW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                w_next_state = ST_IDLE;
                w_timer      = {TW{1'b0}};
            end
        endcase
    end

    // Registered outputs and datapath; READY/BUSY follow the state being entered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_en  <= 1'b0;
            r_dout   <= {DATA_WIDTH{1'b0}};
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
            r_ovfl   <= 1'b0;
            r_wcount <= {CW{1'b0}};
            r_timer  <= {TW{1'b0}};
        end else begin
            r_wr_en  <= w_wr_en;
            r_dout   <= w_dout;
            r_ready  <= (w_next_state == ST_READY);
            r_busy   <= (w_next_state != ST_IDLE);
            r_ovfl   <= w_ovfl;
            r_wcount <= w_wcount;
            r_timer  <= w_timer;
        end
    end

    assign o_wr_en  = r_wr_en;
    assign o_dout   = r_dout;
    assign o_ready  = r_ready;
    assign o_busy   = r_busy;
    assign o_ovfl   = r_ovfl;
    assign o_wcount = r_wcount;

endmodule
